// File: rtl/nios2_div_pkg.sv
// Shared types and constants for the Nios II iterative divider cell.
package nios2_div_pkg;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = $clog2(DIV_W);

    localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nios2_div_cell_if.sv
// CPU <-> divider handshake and result bundle.
interface nios2_div_cell_if #(
    parameter int unsigned DATA_W = 32
);
    logic              A_div_start;
    logic              A_div_signed;
    logic [DATA_W-1:0] A_div_src1;
    logic [DATA_W-1:0] A_div_src2;
    logic              A_div_busy;
    logic              A_div_done;
    logic [DATA_W-1:0] A_div_quotient;
    logic [DATA_W-1:0] A_div_remainder;
    logic              A_div_by_zero;

    modport master (
        output A_div_start, A_div_signed, A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );
endinterface

// File: rtl/nios2_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module nios2_div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dvd_msb,
    input  logic [W-1:0] i_dvs,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);
    logic [W:0] w_shift;
    logic [W:0] w_trial;

    assign w_shift = {i_rem, i_dvd_msb};
    assign w_trial = w_shift - {1'b0, i_dvs};

    // Borrow (bit W) means the divisor did not fit: restore the shifted value.
    assign o_qbit = ~w_trial[W];
    assign o_rem  = w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
endmodule

// File: rtl/nios2_div_cell.sv
// Iterative radix-2 restoring divider for div/divu; DATA_W+2 cycles start-to-done.
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    nios2_div_cell_if.slave  div_if
);
    localparam int unsigned CW = $clog2(DATA_W);

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_remo;
    logic              r_qsign;
    logic              r_rsign;
    logic              r_zero;
    logic              r_busy;
    logic              r_done;
    logic              r_bz;

    logic              w_accept;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_fix;
    logic [DATA_W-1:0] w_mag1;
    logic [DATA_W-1:0] w_mag2;
    logic [DATA_W-1:0] w_rem_nxt;
    logic              w_qbit;

    assign w_mag1 = (div_if.A_div_signed && div_if.A_div_src1[DATA_W-1]) ?
                    DATA_W'(-div_if.A_div_src1) : div_if.A_div_src1;
    assign w_mag2 = (div_if.A_div_signed && div_if.A_div_src2[DATA_W-1]) ?
                    DATA_W'(-div_if.A_div_src2) : div_if.A_div_src2;

    nios2_div_step #(.W(DATA_W)) u_step (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[DATA_W-1]),
        .i_dvs     (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (div_if.A_div_start) w_state_nxt = RUN;
            RUN:     if (r_cnt == '0)        w_state_nxt = FIX;
            FIX:                             w_state_nxt = DONE;
            DONE:    w_state_nxt = div_if.A_div_start ? RUN : IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        w_accept   = 1'b0;
        w_fix      = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if ((r_state == IDLE || r_state == DONE) && div_if.A_div_start) w_accept = 1'b1;
        if (r_state == FIX) w_fix = 1'b1;
        if (w_state_nxt == RUN || w_state_nxt == FIX) w_busy_nxt = 1'b1;
        if (w_state_nxt == DONE) w_done_nxt = 1'b1;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_src1  <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bz    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_dvd   <= w_mag1;
                r_dvs   <= w_mag2;
                r_rem   <= '0;
                r_src1  <= div_if.A_div_src1;
                r_qsign <= div_if.A_div_signed &
                           (div_if.A_div_src1[DATA_W-1] ^ div_if.A_div_src2[DATA_W-1]);
                r_rsign <= div_if.A_div_signed & div_if.A_div_src1[DATA_W-1];
                r_zero  <= (div_if.A_div_src2 == '0);
                r_cnt   <= CW'(DATA_W - 1);
            end else if (r_state == RUN) begin
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_fix) begin
                // Divide-by-zero still runs the full count; results are forced here.
                r_quot <= r_zero ? {DATA_W{1'b1}} : (r_qsign ? DATA_W'(-r_dvd) : r_dvd);
                r_remo <= r_zero ? r_src1 : (r_rsign ? DATA_W'(-r_rem) : r_rem);
                r_bz   <= r_zero;
            end
        end
    end

    assign div_if.A_div_busy      = r_busy;
    assign div_if.A_div_done      = r_done;
    assign div_if.A_div_quotient  = r_quot;
    assign div_if.A_div_remainder = r_remo;
    assign div_if.A_div_by_zero   = r_bz;
endmodule
